// File: rtl/prelude_pkg.sv
// Shared types and constants for the prelude core: opcodes, ALU and
// condition codes, FSM states and the special COPY register indices.
package prelude_pkg;

   typedef enum logic [1:0] {
      OP_IMM  = 2'd0,
      OP_ALU  = 2'd1,
      OP_COPY = 2'd2,
      OP_COND = 2'd3
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_OR   = 3'd0,
      ALU_NAND = 3'd1,
      ALU_NOR  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_ADD  = 3'd4,
      ALU_SUB  = 3'd5,
      ALU_XOR  = 3'd6,
      ALU_XNOR = 3'd7
   } alu_op_e;

   typedef enum logic [2:0] {
      CND_NEVER  = 3'd0,
      CND_ZERO   = 3'd1,
      CND_NEG    = 3'd2,
      CND_LE     = 3'd3,
      CND_ALWAYS = 3'd4,
      CND_NZ     = 3'd5,
      CND_GE     = 3'd6,
      CND_GT     = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXEC    = 2'd1,
      WAIT_IN = 2'd2
   } state_e;

   localparam logic [2:0] REG_IO   = 3'd6;
   localparam logic [2:0] REG_NULL = 3'd7;
   localparam int         NUM_REGS = 6;

endpackage

// File: rtl/prelude_alu.sv
// Combinational ALU and branch-condition evaluator for the prelude core.
// The condition input is treated as a signed two's-complement value.
module prelude_alu
   import prelude_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [2:0]        i_op,
   input  logic [2:0]        i_cond,
   input  logic [DATA_W-1:0] i_test,
   output logic [DATA_W-1:0] o_result,
   output logic              o_cond_true
);

   logic w_zero;
   logic w_neg;

   assign w_zero = (i_test == '0);
   assign w_neg  = i_test[DATA_W-1];

   always_comb begin
      o_result = '0;
      case (alu_op_e'(i_op))
         ALU_OR:   o_result = i_a | i_b;
         ALU_NAND: o_result = ~(i_a & i_b);
         ALU_NOR:  o_result = ~(i_a | i_b);
         ALU_AND:  o_result = i_a & i_b;
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_XNOR: o_result = ~(i_a ^ i_b);
         default:  o_result = '0;
      endcase
   end

   always_comb begin
      o_cond_true = 1'b0;
      case (cond_e'(i_cond))
         CND_NEVER:  o_cond_true = 1'b0;
         CND_ZERO:   o_cond_true = w_zero;
         CND_NEG:    o_cond_true = w_neg;
         CND_LE:     o_cond_true = w_neg | w_zero;
         CND_ALWAYS: o_cond_true = 1'b1;
         CND_NZ:     o_cond_true = ~w_zero;
         CND_GE:     o_cond_true = ~w_neg;
         CND_GT:     o_cond_true = ~w_neg & ~w_zero;
         default:    o_cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/prelude_core.sv
// Parametrised prelude CPU core: fetch/exec FSM, pc, ir, r0-r5 and I/O.
// Fetch: imem_req is held with imem_addr stable until imem_valid; input: in_ack pulses in the cycle in_data is taken.
module prelude_core
   import prelude_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [7:0]        imem_data,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ack,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] pc_dbg,
   output state_e            state_dbg
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              r_imem_req;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;

   opcode_e           w_op;
   logic [2:0]        w_src;
   logic [2:0]        w_dst;
   logic [DATA_W-1:0] w_src_val;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_cond_true;
   logic              w_io_read;
   logic              w_stall;
   logic              w_commit;
   logic              w_wr_en;
   logic [2:0]        w_wr_idx;
   logic [DATA_W-1:0] w_wr_data;
   logic              w_out_wr;
   logic [ADDR_W-1:0] w_pc_next;

   prelude_alu #(.DATA_W(DATA_W)) u_alu (
      .i_a         (r_regs[1]),
      .i_b         (r_regs[2]),
      .i_op        (r_ir[2:0]),
      .i_cond      (r_ir[2:0]),
      .i_test      (r_regs[3]),
      .o_result    (w_alu_res),
      .o_cond_true (w_cond_true)
   );

   always_comb begin
      w_op  = opcode_e'(r_ir[7:6]);
      w_src = r_ir[5:3];
      w_dst = r_ir[2:0];
      w_src_val = '0;
      case (w_src)
         3'd0:     w_src_val = r_regs[0];
         3'd1:     w_src_val = r_regs[1];
         3'd2:     w_src_val = r_regs[2];
         3'd3:     w_src_val = r_regs[3];
         3'd4:     w_src_val = r_regs[4];
         3'd5:     w_src_val = r_regs[5];
         REG_IO:   w_src_val = in_data;
         REG_NULL: w_src_val = '0;
         default:  w_src_val = '0;
      endcase
      // A COPY from I/O parks in WAIT_IN until data arrives; nothing commits meanwhile.
      w_io_read = (w_op == OP_COPY) && (w_src == REG_IO);
      w_stall   = (r_state == EXEC) && w_io_read && !in_valid;
      w_commit  = ((r_state == EXEC) && !w_stall) || ((r_state == WAIT_IN) && in_valid);
      in_ack    = w_commit && w_io_read;

      w_wr_en   = 1'b0;
      w_wr_idx  = 3'd0;
      w_wr_data = w_src_val;
      w_out_wr  = 1'b0;
      w_pc_next = r_pc + ADDR_W'(1);
      case (w_op)
         OP_IMM: begin
            w_wr_en   = 1'b1;
            w_wr_idx  = 3'd0;
            w_wr_data = DATA_W'(r_ir[5:0]);
         end
         OP_ALU: begin
            w_wr_en   = 1'b1;
            w_wr_idx  = 3'd3;
            w_wr_data = w_alu_res;
         end
         OP_COPY: begin
            w_wr_en   = (w_dst < REG_IO);
            w_wr_idx  = w_dst;
            w_wr_data = w_src_val;
            w_out_wr  = (w_dst == REG_IO);
         end
         OP_COND: begin
            if (w_cond_true) w_pc_next = ADDR_W'(r_regs[0]);
         end
         default: w_wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FETCH;
         r_pc        <= '0;
         r_ir        <= '0;
         r_imem_req  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            FETCH: begin
               if (!r_imem_req) begin
                  r_imem_req <= 1'b1;
               end else if (imem_valid) begin
                  r_ir       <= imem_data;
                  r_imem_req <= 1'b0;
                  r_state    <= EXEC;
               end
            end
            EXEC:    if (w_stall) r_state <= WAIT_IN;
            WAIT_IN: r_state <= WAIT_IN;
            default: r_state <= FETCH;
         endcase
         // The commit overrides the state update above and reopens the fetch.
         if (w_commit) begin
            r_pc       <= w_pc_next;
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
            for (int k = 0; k < NUM_REGS; k++) begin
               if (w_wr_en && (w_wr_idx == 3'(k))) r_regs[k] <= w_wr_data;
            end
            if (w_out_wr) begin
               r_out_data  <= w_wr_data;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_pc;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign pc_dbg    = r_pc;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_prelude_core.sv
// Bench for prelude_core: directed steps plus random programs checked
// against an instruction-level model of the prelude ISA.
module tb_prelude_core;
   import prelude_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_valid = 1'b0;
   logic [7:0]  imem_data = 8'h00;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        imem_req, in_ack, out_valid;
   logic [7:0]  imem_addr, out_data, pc_dbg;
   state_e      state_dbg;

   logic        w_imem_req, w_imem_valid, w_in_ack, w_out_valid;
   logic [7:0]  w_imem_data;
   logic [9:0]  w_imem_addr, w_pc;
   logic [15:0] w_out_data;
   logic [15:0] w_in_data = 16'h0000;
   logic        w_in_valid = 1'b0;
   state_e      w_state;

   logic [7:0]  mem   [0:255];
   logic [7:0]  mem_w [0:1023];
   logic [7:0]  in_vals [0:255];
   logic [7:0]  exp_q[$];
   logic [7:0]  pc_q[$];

   int n_tests = 0, n_fail = 0;
   int fetch_cnt, ack_cnt, in_idx, wait_cnt, cur_delay, fetch_delay = 0;
   bit hold_fetch, spur, rand_delay, rand_in, pc_chk, in_ack_seen, dir_in_valid;
   logic [7:0] spur_data, dir_in_data;

   always #5 clk = ~clk;

   prelude_core #(.DATA_W(8), .ADDR_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data), .in_data(in_data),
      .in_valid(in_valid), .in_ack(in_ack), .out_data(out_data),
      .out_valid(out_valid), .pc_dbg(pc_dbg), .state_dbg(state_dbg)
   );

   assign w_imem_valid = w_imem_req;
   assign w_imem_data  = mem_w[w_imem_addr];

   prelude_core #(.DATA_W(16), .ADDR_W(10)) u_wide (
      .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_valid(w_imem_valid), .imem_data(w_imem_data), .in_data(w_in_data),
      .in_valid(w_in_valid), .in_ack(w_in_ack), .out_data(w_out_data),
      .out_valid(w_out_valid), .pc_dbg(w_pc), .state_dbg(w_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // One clock: retire the previous edge's input ack, check outputs, drive memory and input port.
   task automatic cycle();
      @(negedge clk);
      if (in_ack_seen) in_idx++;
      if (out_valid) begin
         chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
      end
      if (imem_req && !hold_fetch && wait_cnt >= cur_delay) begin
         imem_valid = 1'b1;
         imem_data  = mem[imem_addr];
         fetch_cnt++;
         if (pc_chk) begin
            chk("pc_q_avail", 32'(pc_q.size() != 0), 32'd1);
            if (pc_q.size() != 0) chk("fetch_pc", imem_addr, pc_q.pop_front());
         end
         wait_cnt  = 0;
         cur_delay = rand_delay ? int'($urandom_range(0, 2)) : fetch_delay;
      end else begin
         if (imem_req && !hold_fetch) wait_cnt++;
         imem_valid = spur;
         imem_data  = spur ? spur_data : 8'h00;
      end
      if (rand_in) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_data  = in_vals[in_idx];
      end else begin
         in_valid = dir_in_valid;
         in_data  = dir_in_data;
      end
      #1;
      in_ack_seen = in_ack;
      if (in_ack) ack_cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_valid = 1'b0; imem_data = 8'h00; in_valid = 1'b0; in_data = 8'h00;
      exp_q.delete(); pc_q.delete();
      fetch_cnt = 0; ack_cnt = 0; in_idx = 0; wait_cnt = 0; cur_delay = fetch_delay;
      hold_fetch = 0; spur = 0; pc_chk = 0; in_ack_seen = 0; dir_in_valid = 0; dir_in_data = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Grant fetches until n instructions were handed out, then stop fetching and let the last one commit.
   task automatic run_to(input int n);
      int cyc = 0;
      hold_fetch = 0;
      while (fetch_cnt < n && cyc < 3000) begin
         cycle();
         cyc++;
      end
      chk("run_to_done", fetch_cnt, n);
      hold_fetch = 1;
      repeat (2) cycle();
   endtask

   // Instruction-level reference: executes mem from pc 0 for n instructions.
   task automatic model_run(input int n, output logic [7:0] pc_end, output int used);
      logic [7:0] r [0:7];
      logic [7:0] pc, ins, a, b, v, pc_n;
      int ii, ti, s, d;
      bit tk;
      for (int i = 0; i < 8; i++) r[i] = 8'h00;
      pc = 8'h00; ii = 0;
      for (int k = 0; k < n; k++) begin
         pc_q.push_back(pc);
         ins  = mem[pc];
         pc_n = pc + 8'd1;
         case (ins[7:6])
            2'd0: r[0] = {2'b00, ins[5:0]};
            2'd1: begin
               a = r[1]; b = r[2];
               case (ins[2:0])
                  3'd0: v = a | b;
                  3'd1: v = ~(a & b);
                  3'd2: v = ~(a | b);
                  3'd3: v = a & b;
                  3'd4: v = a + b;
                  3'd5: v = a - b;
                  3'd6: v = a ^ b;
                  default: v = ~(a ^ b);
               endcase
               r[3] = v;
            end
            2'd2: begin
               s = int'(ins[5:3]); d = int'(ins[2:0]);
               if (s < 6) v = r[s];
               else if (s == 6) begin v = in_vals[ii]; ii++; end
               else v = 8'h00;
               if (d < 6) r[d] = v;
               else if (d == 6) exp_q.push_back(v);
            end
            default: begin
               ti = int'($signed(r[3]));
               case (ins[2:0])
                  3'd0: tk = 0;
                  3'd1: tk = (ti == 0);
                  3'd2: tk = (ti < 0);
                  3'd3: tk = (ti <= 0);
                  3'd4: tk = 1;
                  3'd5: tk = (ti != 0);
                  3'd6: tk = (ti >= 0);
                  default: tk = (ti > 0);
               endcase
               if (tk) pc_n = r[0];
            end
         endcase
         pc = pc_n;
      end
      pc_end = pc;
      used = ii;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] p_alu [14] = '{8'h05, 8'h81, 8'h03, 8'h82, 8'h44, 8'h9E, 8'h45,
                                 8'h9E, 8'h00, 8'h81, 8'h01, 8'h82, 8'h45, 8'h9E};
      logic [7:0] m_pc;
      int m_used, acks0;
      bit seen_out, seen_3ff, seen_wrap;

      for (int i = 0; i < 1024; i++) mem_w[i] = 8'h00;
      clear_mem();

      // Reset values while rst_n is held low from time zero.
      @(negedge clk);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_in_ack", in_ack, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_pc", pc_dbg, 8'h00);
      chk("rst_state", state_dbg, FETCH);

      // Zero-wait fetch of a stream of 0x00: one instruction every 2 cycles.
      do_reset();
      chk("req_low_at_release", imem_req, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("stream_req", imem_req, 1'b1);
         chk("stream_addr", imem_addr, 8'(k));
         chk("stream_pc", pc_dbg, 8'(k));
         cycle();
         chk("stream_exec_req", imem_req, 1'b0);
      end

      // IMM + ALU: ADD -> 8, SUB -> 2, 0-1 -> 0xFF, each copied to the I/O register.
      clear_mem();
      for (int i = 0; i < 14; i++) mem[i] = p_alu[i];
      do_reset();
      exp_q.push_back(8'h08); exp_q.push_back(8'h02); exp_q.push_back(8'hFF);
      run_to(14);
      cycle();
      chk("alu_outs_done", exp_q.size(), 0);
      chk("alu_pc", pc_dbg, 8'd14);

      // Branches: taken <0, not-taken >=0, always to 0xFF, and pc wrap to 0.
      clear_mem();
      mem[8'h00] = 8'h42; mem[8'h01] = 8'h10; mem[8'h02] = 8'hC2;
      mem[8'h10] = 8'hC6; mem[8'h11] = 8'h98; mem[8'h12] = 8'hC4; mem[8'hFF] = 8'h00;
      do_reset();
      run_to(3); chk("br_taken_neg", pc_dbg, 8'h10);
      run_to(4); chk("br_nottaken_ge", pc_dbg, 8'h11);
      run_to(6); chk("br_always_ff", pc_dbg, 8'hFF);
      run_to(7); chk("pc_wrap", pc_dbg, 8'h00);

      // COPY io->io with input withheld: WAIT_IN, pc held, then a single ack.
      clear_mem();
      mem[0] = 8'hB6;
      do_reset();
      run_to(1);
      chk("io_wait_state", state_dbg, WAIT_IN);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("io_wait_noack", in_ack, 1'b0);
         chk("io_wait_pc", pc_dbg, 8'h00);
         chk("io_wait_hold", state_dbg, WAIT_IN);
      end
      acks0 = ack_cnt;
      exp_q.push_back(8'h5A);
      dir_in_data = 8'h5A; dir_in_valid = 1;
      cycle();
      chk("io_ack", in_ack, 1'b1);
      dir_in_valid = 0;
      cycle();
      chk("io_out_valid", out_valid, 1'b1);
      chk("io_out_data", out_data, 8'h5A);
      chk("io_pc", pc_dbg, 8'h01);
      cycle();
      chk("io_out_pulse", out_valid, 1'b0);
      chk("io_out_held", out_data, 8'h5A);
      chk("io_ack_count", ack_cnt - acks0, 1);
      chk("io_out_done", exp_q.size(), 0);

      // Fetch with 3 wait cycles, then a spurious imem_valid while in EXEC.
      clear_mem();
      mem[0] = 8'h05; mem[1] = 8'h86;
      fetch_delay = 3;
      do_reset();
      cycle();
      for (int k = 0; k < 3; k++) begin
         chk("ws_req_held", imem_req, 1'b1);
         chk("ws_addr_held", imem_addr, 8'h00);
         cycle();
      end
      chk("ws_one_fetch", fetch_cnt, 1);
      spur = 1; spur_data = 8'h9E;
      cycle();
      spur = 0;
      cycle();
      chk("ws_pc_after", pc_dbg, 8'h01);
      chk("ws_state_after", state_dbg, FETCH);
      exp_q.push_back(8'h05);
      run_to(2);
      cycle();
      chk("ws_out_done", exp_q.size(), 0);
      chk("ws_pc_final", pc_dbg, 8'h02);
      fetch_delay = 0;

      // Async reset while waiting for input with in_valid raised.
      clear_mem();
      mem[0] = 8'h3F; mem[1] = 8'h86; mem[2] = 8'hB6;
      do_reset();
      exp_q.push_back(8'h3F);
      run_to(3);
      chk("rw_state", state_dbg, WAIT_IN);
      chk("rw_out_before", out_data, 8'h3F);
      dir_in_valid = 1; dir_in_data = 8'hA5;
      cycle();
      chk("rw_ack_before", in_ack, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_ack_drop", in_ack, 1'b0);
      chk("rw_req_drop", imem_req, 1'b0);
      chk("rw_out_data", out_data, 8'h00);
      chk("rw_out_valid", out_valid, 1'b0);
      chk("rw_pc", pc_dbg, 8'h00);
      do_reset();
      cycle();
      chk("rw_refetch_req", imem_req, 1'b1);
      chk("rw_refetch_addr", imem_addr, 8'h00);

      // Random programs with random fetch latency and input availability.
      for (int run = 0; run < 4; run++) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            in_vals[i] = 8'($urandom);
         end
         do_reset();
         rand_delay = 1; rand_in = 1; cur_delay = 0;
         model_run(150, m_pc, m_used);
         pc_chk = 1;
         run_to(150);
         repeat (30) cycle();
         chk("rnd_outs_done", exp_q.size(), 0);
         chk("rnd_pcs_done", pc_q.size(), 0);
         chk("rnd_in_used", in_idx, m_used);
         chk("rnd_pc_end", pc_dbg, m_pc);
         rand_delay = 0; rand_in = 0;
      end

      // Wide instance: DATA_W=16, ADDR_W=10, 0-1 wraps to 0xFFFF, branch to r0[9:0].
      mem_w[0] = 8'h01; mem_w[1] = 8'h82; mem_w[2] = 8'h45;
      mem_w[3] = 8'h9E; mem_w[4] = 8'h98; mem_w[5] = 8'hC4;
      do_reset();
      seen_out = 0; seen_3ff = 0; seen_wrap = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (w_out_valid && !seen_out) begin
            seen_out = 1;
            chk("w_out_data", w_out_data, 16'hFFFF);
         end
         if (seen_3ff && !seen_wrap && w_pc != 10'h3FF) begin
            seen_wrap = 1;
            chk("w_pc_wrap", w_pc, 10'h000);
         end
         if (w_pc == 10'h3FF) seen_3ff = 1;
      end
      chk("w_seen_out", seen_out, 1'b1);
      chk("w_seen_3ff", seen_3ff, 1'b1);
      chk("w_seen_wrap", seen_wrap, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prelude_core.md
Name: prelude_core

Overview:
- Parametrised second-generation prelude CPU core.
- Executes the 8-bit prelude ISA with these generalisations:
  - data width of DATA_W
  - program address width of ADDR_W
  - external instruction memory reached through a req/valid fetch handshake
  - flow-controlled input port and strobed output port
  - asynchronous active-low reset
- Sits between the instruction memory/ROM and the board I/O.
- Replaces the fixed-width, reset-less, combinational-ROM core.

Parameters:
- DATA_W, 8, width of registers r0-r5, ALU and I/O data; minimum 6.
- ADDR_W, 8, width of pc and imem_addr; branch target is r0[ADDR_W-1:0], zero-extended when ADDR_W > DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  ADDR_W  fetch address (= pc); stable while imem_req is high.
- imem_valid  in  1  imem_data valid this cycle; ignored when imem_req is low.
- imem_data  in  8  instruction byte.
- in_data  in  DATA_W  input port data.
- in_valid  in  1  in_data available.
- in_ack  out  1  one-cycle pulse; in_data consumed this cycle.
- out_data  out  DATA_W  last value written to the I/O register (held).
- out_valid  out  1  one-cycle pulse when out_data is updated.
- pc_dbg  out  ADDR_W  current pc, for benches.

Behaviour:
- Reset (async assert, sync deassert upstream) forces the following; the core leaves reset in FETCH.
  - pc=0, ir=0, r0-r5=0, state=FETCH
  - imem_req=0, in_ack=0, out_valid=0, out_data=0
- imem_req goes high the first clock after reset release.
- FSM states: FETCH, EXEC, WAIT_IN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_valid=1, ir<=imem_data and go to EXEC.
  - Zero-wait memory, where valid arrives in the same cycle as req, is legal.
  - Best case is 2 cycles per instruction.
- EXEC: decode ir[7:6].
  - 00 IMM: r0 <= zero-extend ir[5:0].
  - 01 ALU: r3 <= f(r1,r2), selected by ir[2:0]. ir[5:3] is ignored.
    - Ops: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1-r2), 6 XOR, 7 XNOR.
    - ADD/SUB wrap modulo 2^DATA_W; there are no flags.
  - 10 COPY: src=ir[5:3], dst=ir[2:0].
    - Indices 0-5 are r0-r5, 6 is I/O, 7 is null (reads 0, writes discarded).
    - If src=6 and in_valid=0: go to WAIT_IN with no writes and pc held.
    - If src=6 and in_valid=1: value=in_data, in_ack pulses this cycle.
    - If dst=6: out_data<=value and out_valid pulses in the cycle after EXEC commits.
    - src=dst=6 reads the input and writes the output in the same commit.
  - 11 COND: r3 is tested as a signed DATA_W value.
    - ir[2:0] codes: 0 never, 1 =0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0. ir[5:3] is ignored.
    - Taken: pc <= r0[ADDR_W-1:0]. Not taken: pc <= pc+1.
  - Every non-branch commit sets pc <= pc+1, wrapping from 2^ADDR_W-1 to 0.
  - Next state is FETCH.
- WAIT_IN:
  - Stall until in_valid=1, then commit the pending COPY exactly as in EXEC (in_ack pulse, pc+1) and go to FETCH.
  - Only one in_ack is issued per COPY.
- Register writes, pc update and in_ack all occur in the single commit cycle. Reads use pre-commit values, so COPY r3->r3 and ALU with dst r3 are well defined.
- imem_valid arriving in EXEC or WAIT_IN is ignored.
- in_valid asserted outside a src=6 commit is not acknowledged.
- Reset asserted mid-fetch or in WAIT_IN drops imem_req and in_ack immediately (async). Any in-flight instruction is discarded.

Decomposition:
- prelude_pkg holds:
  - opcode enum {OP_IMM, OP_ALU, OP_COPY, OP_COND}
  - alu_op_e (8 codes)
  - cond_e (8 codes)
  - state_e {FETCH, EXEC, WAIT_IN}
  - constants REG_IO=3'd6 and REG_NULL=3'd7
- One combinational sub-module, prelude_alu, parametrised by DATA_W, provides:
  - inputs a, b, op[2:0], cond[2:0], test value
  - outputs result and cond_true
- The core holds the FSM, pc, ir, register file and I/O.

Test Plan:
- Reset/fetch: release rst_n with zero-wait memory -> imem_req high next cycle, imem_addr=0, pc_dbg increments by 1 every 2 cycles on a stream of 0x00.
- IMM+ALU: DATA_W=8, program 0x05 (r0=5), COPY r0->r1 (0x81), 0x03 (r0=3), COPY r0->r2 (0x82), 0x44 (ADD) -> r3=8; repeating with 0x45 (SUB) -> r3=2; with r1=0, r2=1, SUB -> r3=0xFF.
- Branch: r0=0x10, r3=0xFF; COND <0 (0xC2) -> pc=0x10; COND >=0 (0xC6) -> pc=old+1; pc at 0xFF with a non-branch instruction -> pc=0x00.
- I/O: COPY io->io (0xB6) with in_valid low for 5 cycles then in_data=0x5A -> state WAIT_IN, pc held, one in_ack, out_data=0x5A with one out_valid pulse.
- Fetch wait states: imem_valid delayed 3 cycles -> imem_req and imem_addr held stable, exactly one instruction executed; a spurious imem_valid in EXEC -> ignored.
- Width/reset: DATA_W=16, ADDR_W=10, r0=0x03FF, COND always (0xC4) -> pc=0x3FF; assert rst_n low in WAIT_IN -> all outputs 0 immediately, refetch from 0.
